answer_arbiter: RTL and testbench
=================================

# answer_arbiter

Front-end controller for the multichannel answering machine. It debounces the host and contestant pushbuttons and locks in the first valid contestant press. It drives the run and clear inputs of the countdown display and consumes the countdown's expiry signal to end the answer window. It sits between the raw board buttons and the countdown/display path, and reports the winner and foul status to the LED/segment logic.

## Interface
- N, 4, number of contestant channels (1..7)
- DEB_CYCLES, 20, consecutive stable clk cycles required before a button level is accepted (≥2)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- host_start  in  1  raw host "start question" button, active-high
- host_clear  in  1  raw host "clear/next round" button, active-high
- btn  in  N  raw contestant buttons, active-high, bit i = channel i
- time_up  in  1  level from countdown, high once the answer time has expired
- cd_run  out  1  countdown run (1) / pause (0)
- cd_clear  out  1  one-cycle pulse restarting the countdown from its full value
- winner  out  3  granted channel index + 1; 0 = no winner
- foul  out  N  sticky mask of channels that pressed before the question was armed
- state  out  2  current FSM state encoding, for display/LED use

## Operation
- All button inputs pass through a per-input debouncer. The filtered level changes only after the raw level has been stable for DEB_CYCLES cycles. A press event is a one-cycle pulse on the filtered 0→1 transition. Releases generate no event.
- States:
  - IDLE=0: waiting for the host.
  - ARMED=1: question open, no winner yet.
  - ANSWER=2: winner granted, countdown running.
  - TIMEOUT=3: answer time expired.
- IDLE:
  - A contestant press event sets foul[i].
  - A host_start event moves to ARMED.
- ARMED:
  - The first contestant press event on a channel with foul[i]=0 moves to ANSWER, sets winner=i+1, and pulses cd_clear.
  - Press events from fouled channels are ignored.
  - Simultaneous eligible events in one cycle: the lowest index wins.
- ANSWER:
  - cd_run=1.
  - Further presses are ignored.
  - time_up=1 moves to TIMEOUT.
- TIMEOUT:
  - cd_run=0.
  - winner is held.
  - All presses are ignored.
- A host_clear event in any state moves to IDLE, clears winner and foul, and pulses cd_clear. host_clear has priority over every other event in the same cycle.
- A host_start event outside IDLE is ignored.
- cd_run=1 only in ANSWER. cd_run is a registered function of state.
- Reset values: state=IDLE, winner=0, foul=0, cd_run=0, cd_clear=0, all debouncer filtered levels 0, all stability counters 0.
- Reset mid-operation (any state, including during a debounce window) returns to these values on the next clk edge. Any in-progress debounce count is discarded.

## Timing
- Raw level stable from edge k → filtered level changes at edge k+DEB_CYCLES → press pulse high during cycle k+DEB_CYCLES.
- FSM, winner, foul, and cd_clear update at edge k+DEB_CYCLES+1. Total press-to-grant latency is DEB_CYCLES+1 cycles.
- cd_run rises at the same edge as the entry to ANSWER.
- cd_clear is high for exactly one cycle per grant or clear.
- time_up is sampled directly; no synchronisation is needed, because it comes from the same clock domain. TIMEOUT is entered one edge after time_up is seen high in ANSWER.
- A glitch shorter than DEB_CYCLES cycles resets the stability counter and produces no event.
- The debouncer counter width is clog2(DEB_CYCLES)+1. The counter saturates and never wraps.

## Structure
- Shared package arbiter_pkg holds:
  - state encoding constants ST_IDLE, ST_ARMED, ST_ANSWER, ST_TIMEOUT
  - NO_WINNER=0
  - the winner field width
- Sub-module debouncer (parameter DEB_CYCLES; ports clk, rst, raw, level, rise) is instantiated N+2 times.
- The top level holds the FSM, priority encoder, foul register and output registers.

## Test plan
- Bench parameters for all scenarios: N=4, DEB_CYCLES=4.
- rst held 2 cycles, then released → state=0, winner=0, foul=0, cd_run=0, cd_clear=0.
- In IDLE, btn[2] held 6 cycles; then host_start held 6 cycles → foul=4'b0100, state=1. A later btn[2] press is ignored, and a btn[1] press gives winner=2, cd_clear pulsed once, and cd_run=1 exactly 5 cycles after btn[1] first went high.
- ARMED, btn[3] and btn[1] rise on the same cycle → winner=2, state=2.
- ARMED, btn[0] pulses high for 3 cycles → no grant, state stays 1. Held for 4 cycles → winner=1.
- ANSWER, time_up asserted → next edge state=3, cd_run=0, winner held. host_clear press then gives state=0, winner=0, foul=0, one cd_clear pulse.
- ANSWER with rst asserted for one cycle while btn[2] is mid-debounce → all outputs at reset values next edge, and no grant follows without a fresh 4-cycle press after host_start.

Source files
------------

// File: rtl/answer_arbiter_pkg.sv
// Shared encodings for the answering-machine arbiter: FSM states and the
// winner field.
package arbiter_pkg;
  localparam int WIN_W = 3;
  localparam logic [WIN_W-1:0] NO_WINNER = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ANSWER  = 2'd2,
    ST_TIMEOUT = 2'd3
  } arb_state_t;
endpackage

// File: rtl/answer_arbiter_if.sv
// Board-side bundle of the arbiter: raw buttons, countdown handshake and
// winner/foul status towards the LED/segment logic.
interface answer_arbiter_if #(parameter int N = 4);
  import arbiter_pkg::*;

  logic             host_start;
  logic             host_clear;
  logic [N-1:0]     btn;
  logic             time_up;
  logic             cd_run;
  logic             cd_clear;
  logic [WIN_W-1:0] winner;
  logic [N-1:0]     foul;
  logic [1:0]       state;

  modport master (
    output host_start, host_clear, btn, time_up,
    input  cd_run, cd_clear, winner, foul, state
  );

  modport slave (
    input  host_start, host_clear, btn, time_up,
    output cd_run, cd_clear, winner, foul, state
  );
endinterface

// File: rtl/answer_arbiter_debouncer.sv
// Level filter: the output follows the raw input only after DEB_CYCLES
// consecutive differing samples; rise pulses for one cycle on each 0->1 change.
module debouncer #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Any sample equal to the current level restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= raw;
        rise  <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/answer_arbiter.sv
// Answering-machine front end: debounces all buttons, locks in the first
// eligible contestant and sequences the countdown run/clear controls.
module answer_arbiter
  import arbiter_pkg::*;
#(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 20
) (
  input  logic             clk,
  input  logic             rst,
  answer_arbiter_if.slave  bus
);
  logic [N-1:0]     btn_rise;
  logic             start_rise;
  logic             clear_rise;
  logic [N-1:0]     eligible;
  logic [WIN_W-1:0] grant;

  arb_state_t       state_q, state_d;
  logic [WIN_W-1:0] winner_q, winner_d;
  logic [N-1:0]     foul_q, foul_d;
  logic             clr_q, clr_d;
  logic             run_q;

  for (genvar i = 0; i < N; i++) begin : g_btn
    debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.btn[i]),
      .level (),
      .rise  (btn_rise[i])
    );
  end

  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(clk), .rst(rst), .raw(bus.host_start), .level(), .rise(start_rise)
  );

  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk(clk), .rst(rst), .raw(bus.host_clear), .level(), .rise(clear_rise)
  );

  // Fouled channels never compete; lowest index wins a same-cycle tie.
  assign eligible = btn_rise & ~foul_q;

  always_comb begin
    grant = NO_WINNER;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) grant = WIN_W'(i + 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    foul_d   = foul_q;
    clr_d    = 1'b0;
    if (clear_rise) begin
      state_d  = ST_IDLE;
      winner_d = NO_WINNER;
      foul_d   = '0;
      clr_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          foul_d = foul_q | btn_rise;
          if (start_rise) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (|eligible) begin
            state_d  = ST_ANSWER;
            winner_d = grant;
            clr_d    = 1'b1;
          end
        end
        ST_ANSWER: begin
          if (bus.time_up) state_d = ST_TIMEOUT;
        end
        ST_TIMEOUT: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      winner_q <= NO_WINNER;
      foul_q   <= '0;
      clr_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      foul_q   <= foul_d;
      clr_q    <= clr_d;
      run_q    <= (state_d == ST_ANSWER);
    end
  end

  assign bus.state    = state_q;
  assign bus.winner   = winner_q;
  assign bus.foul     = foul_q;
  assign bus.cd_clear = clr_q;
  assign bus.cd_run   = run_q;
endmodule

// File: tb/tb_answer_arbiter.sv
// Self-checking bench for answer_arbiter: directed vector table, hand-written
// timing/reset sequences, then random stimulus against a behavioural model.
module tb_answer_arbiter;
  import arbiter_pkg::*;

  localparam int N   = 4;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  answer_arbiter_if #(.N(N)) bus ();

  answer_arbiter #(.N(N), .DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic       r;
    logic       hs;
    logic       hc;
    logic [3:0] b;
    logic       tu;
    int         cyc;
    logic [1:0] st;
    logic [2:0] w;
    logic [3:0] f;
    logic       run;
    int         clr;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: each filtered level flips once its last DEB samples all
  // disagree with it; the game rules act on the previous cycle's press events.
  logic [DEB-1:0] m_hist [N+2];
  logic [N+1:0]   m_filt;
  logic [N+1:0]   m_rise;
  int             m_state;
  int             m_winner;
  logic [N-1:0]   m_foul;
  logic           m_run;
  logic           m_clr;

  task automatic model_tick();
    logic [N+1:0] raw;
    logic [N+1:0] new_rise;
    logic [N-1:0] elig;
    raw = {bus.host_clear, bus.host_start, bus.btn};
    if (rst) begin
      for (int j = 0; j < N + 2; j++) m_hist[j] = '0;
      m_filt = '0; m_rise = '0; m_state = 0; m_winner = 0;
      m_foul = '0; m_run = 1'b0; m_clr = 1'b0;
    end else begin
      m_clr = 1'b0;
      if (m_rise[N+1]) begin
        m_state = 0; m_winner = 0; m_foul = '0; m_clr = 1'b1;
      end else begin
        case (m_state)
          0: begin
            m_foul = m_foul | m_rise[N-1:0];
            if (m_rise[N]) m_state = 1;
          end
          1: begin
            elig = m_rise[N-1:0] & ~m_foul;
            for (int i = 0; i < N; i++) begin
              if (elig[i]) begin
                m_winner = i + 1; m_state = 2; m_clr = 1'b1;
                break;
              end
            end
          end
          2: if (bus.time_up) m_state = 3;
          default: ;
        endcase
      end
      m_run = (m_state == 2);
      new_rise = '0;
      for (int j = 0; j < N + 2; j++) begin
        m_hist[j] = {m_hist[j][DEB-2:0], raw[j]};
        if (!m_filt[j] && m_hist[j] == '1) begin
          m_filt[j] = 1'b1; new_rise[j] = 1'b1;
        end else if (m_filt[j] && m_hist[j] == '0) begin
          m_filt[j] = 1'b0;
        end
      end
      m_rise = new_rise;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic hs, input logic hc,
                       input logic [3:0] b, input logic tu);
    rst = r; bus.host_start = hs; bus.host_clear = hc; bus.btn = b; bus.time_up = tu;
  endtask

  task automatic add(input logic r, input logic hs, input logic hc, input logic [3:0] b,
                     input logic tu, input int cyc, input logic [1:0] st, input logic [2:0] w,
                     input logic [3:0] f, input logic run, input int clr);
    vec_t v;
    v.r = r; v.hs = hs; v.hc = hc; v.b = b; v.tu = tu; v.cyc = cyc;
    v.st = st; v.w = w; v.f = f; v.run = run; v.clr = clr;
    tbl.push_back(v);
  endtask

  task automatic apply_row(input int i);
    int clr_cnt;
    drive(tbl[i].r, tbl[i].hs, tbl[i].hc, tbl[i].b, tbl[i].tu);
    clr_cnt = 0;
    repeat (tbl[i].cyc) begin
      step();
      clr_cnt += int'(bus.cd_clear);
    end
    check($sformatf("row%0d.out", i),
          32'({bus.state, bus.winner, bus.foul, bus.cd_run}),
          32'({tbl[i].st, tbl[i].w, tbl[i].f, tbl[i].run}));
    check($sformatf("row%0d.clr_pulses", i), 32'(clr_cnt), 32'(tbl[i].clr));
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

    //   r  hs hc btn     tu cyc st     w     foul     run clr
    add(1, 0, 0, 4'b0000, 0, 2, 2'd0, 3'd0, 4'b0000, 0, 0);   // 0 reset
    add(0, 0, 0, 4'b0000, 0, 2, 2'd0, 3'd0, 4'b0000, 0, 0);   // 1
    add(0, 0, 0, 4'b0100, 0, 6, 2'd0, 3'd0, 4'b0100, 0, 0);   // 2 early press -> foul
    add(0, 1, 0, 4'b0000, 0, 6, 2'd1, 3'd0, 4'b0100, 0, 0);   // 3 start -> ARMED
    add(0, 0, 0, 4'b0000, 0, 6, 2'd1, 3'd0, 4'b0100, 0, 0);   // 4
    add(0, 0, 0, 4'b0100, 0, 6, 2'd1, 3'd0, 4'b0100, 0, 0);   // 5 fouled press ignored
    add(0, 0, 0, 4'b0000, 0, 6, 2'd1, 3'd0, 4'b0100, 0, 0);   // 6
    add(0, 0, 1, 4'b0000, 0, 6, 2'd0, 3'd0, 4'b0000, 0, 1);   // 7 clear
    add(0, 0, 0, 4'b0000, 0, 6, 2'd0, 3'd0, 4'b0000, 0, 0);   // 8
    add(0, 1, 0, 4'b0000, 0, 6, 2'd1, 3'd0, 4'b0000, 0, 0);   // 9
    add(0, 0, 0, 4'b0000, 0, 6, 2'd1, 3'd0, 4'b0000, 0, 0);   // 10
    add(0, 0, 0, 4'b1010, 0, 6, 2'd2, 3'd2, 4'b0000, 1, 1);   // 11 tie -> lowest
    add(0, 0, 0, 4'b0000, 1, 1, 2'd3, 3'd2, 4'b0000, 0, 0);   // 12 time_up next edge
    add(0, 0, 0, 4'b0000, 0, 6, 2'd3, 3'd2, 4'b0000, 0, 0);   // 13 winner held
    add(0, 0, 1, 4'b0000, 0, 6, 2'd0, 3'd0, 4'b0000, 0, 1);   // 14 clear
    add(0, 0, 0, 4'b0000, 0, 6, 2'd0, 3'd0, 4'b0000, 0, 0);   // 15
    add(0, 1, 0, 4'b0000, 0, 6, 2'd1, 3'd0, 4'b0000, 0, 0);   // 16
    add(0, 0, 0, 4'b0000, 0, 6, 2'd1, 3'd0, 4'b0000, 0, 0);   // 17
    add(0, 0, 0, 4'b0001, 0, 3, 2'd1, 3'd0, 4'b0000, 0, 0);   // 18 3-cycle glitch
    add(0, 0, 0, 4'b0000, 0, 6, 2'd1, 3'd0, 4'b0000, 0, 0);   // 19 no grant
    add(0, 0, 0, 4'b0001, 0, 4, 2'd1, 3'd0, 4'b0000, 0, 0);   // 20 exactly 4 samples
    add(0, 0, 0, 4'b0000, 0, 6, 2'd2, 3'd1, 4'b0000, 1, 1);   // 21 grant lands
    add(0, 1, 0, 4'b0000, 0, 6, 2'd1, 3'd0, 4'b0000, 0, 0);   // 22 after reset seq
    add(0, 0, 0, 4'b0000, 0, 6, 2'd1, 3'd0, 4'b0000, 0, 0);   // 23
    add(0, 0, 0, 4'b0100, 0, 6, 2'd2, 3'd3, 4'b0000, 1, 1);   // 24 fresh press grants
    add(0, 0, 0, 4'b0000, 0, 6, 2'd2, 3'd3, 4'b0000, 1, 0);   // 25

    for (int i = 0; i <= 6; i++) apply_row(i);

    // Press-to-grant latency: cd_run must appear exactly 5 cycles after btn[1] rises.
    drive(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    for (int t = 1; t <= 6; t++) begin
      step();
      check($sformatf("lat.cd_run@%0d", t), 32'(bus.cd_run), 32'(t >= 5));
      check($sformatf("lat.cd_clear@%0d", t), 32'(bus.cd_clear), 32'(t == 5));
    end
    check("lat.grant", 32'({bus.state, bus.winner, bus.foul}),
          32'({2'd2, 3'd2, 4'b0100}));

    for (int i = 7; i <= 21; i++) apply_row(i);

    // Reset in ANSWER with btn[2] mid-debounce; the partial count must be lost.
    drive(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    step(); step();
    drive(1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
    step();
    check("rst.outputs", 32'({bus.state, bus.winner, bus.foul, bus.cd_run, bus.cd_clear}), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    step(); step(); step();
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    repeat (6) step();
    check("rst.no_event", 32'({bus.state, bus.winner, bus.foul, bus.cd_clear}), 32'd0);

    for (int i = 22; i <= 25; i++) apply_row(i);

    // Random segments of held input patterns, checked every cycle.
    for (int seg = 0; seg < 400; seg++) begin
      logic [3:0] b;
      int hold;
      b = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 11) == 0), b, 1'($urandom_range(0, 1)));
      hold = $urandom_range(1, 8);
      repeat (hold) begin
        step();
        check($sformatf("rand.seg%0d", seg),
              32'({bus.state, bus.winner, bus.foul, bus.cd_run, bus.cd_clear}),
              32'({2'(m_state), 3'(m_winner), m_foul, m_run, m_clr}));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
